// File: rtl/clint_timer_ctrl.sv
// CLINT machine timer: prescaled 64-bit mtime, per-hart mtimecmp/mtip and msip registers.
// Optional macro CLINT_TIME_STOP_EN adds a time_stop input that freezes mtime and the prescaler.
module clint_timer_ctrl #(
  parameter int HART_NUM = 1,
  parameter int TICK_DIV = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef CLINT_TIME_STOP_EN
  input  logic                     time_stop,
`endif
  input  logic                     mtime_wen,
  input  logic [HART_NUM-1:0]      mtimecmp_wen,
  input  logic [HART_NUM-1:0]      msip_wen,
  input  logic [63:0]              reg_wdata,
  output logic [63:0]              mtime,
  output logic [64*HART_NUM-1:0]   mtimecmp,
  output logic [HART_NUM-1:0]      msip,
  output logic [HART_NUM-1:0]      mtip
);

  localparam int            PW         = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic [63:0]   mtime_nxt_s;
  logic          tick_s;
  logic          run_s;

`ifdef CLINT_TIME_STOP_EN
  assign run_s = ~time_stop;
`else
  assign run_s = 1'b1;
`endif

  assign tick_s = (presc_r == PRESC_LAST);

  // Timebase next state: a software write wins over a tick and restarts the prescaler.
  always_comb begin
    presc_nxt_s = presc_r;
    mtime_nxt_s = mtime;
    if (mtime_wen) begin
      mtime_nxt_s = reg_wdata;
      presc_nxt_s = '0;
    end else if (run_s) begin
      if (tick_s) begin
        mtime_nxt_s = mtime + 64'd1;
        presc_nxt_s = '0;
      end else begin
        presc_nxt_s = presc_r + PRESC_ONE;
      end
    end else begin
      presc_nxt_s = presc_r;
      mtime_nxt_s = mtime;
    end
  end

  // State registers; mtip compares the current registered values, so it lags by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r  <= '0;
      mtime    <= 64'd0;
      mtimecmp <= '1;
      msip     <= '0;
      mtip     <= '0;
    end else begin
      presc_r <= presc_nxt_s;
      mtime   <= mtime_nxt_s;
      for (int i = 0; i < HART_NUM; i++) begin
        if (mtimecmp_wen[i]) begin
          mtimecmp[64*i +: 64] <= reg_wdata;
        end
        // Odd harts take their msip bit from the upper word of the merged write bus.
        if (msip_wen[i]) begin
          msip[i] <= ((i % 2) == 1) ? reg_wdata[32] : reg_wdata[0];
        end
        mtip[i] <= (mtime >= mtimecmp[64*i +: 64]);
      end
    end
  end

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Randomized self-checking bench for clint_timer_ctrl: two instances (TICK_DIV 4 and 1, two harts)
// share stimulus and are compared every cycle against an edge-count model of the timer.
module tb_clint_timer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        time_stop;
  logic        mtime_wen;
  logic [1:0]  mtimecmp_wen;
  logic [1:0]  msip_wen;
  logic [63:0] reg_wdata;

  logic [63:0]  mtime_o    [2];
  logic [127:0] mtimecmp_o [2];
  logic [1:0]   msip_o     [2];
  logic [1:0]   mtip_o     [2];

  int checks = 0;
  int errors = 0;

  clint_timer_ctrl #(.HART_NUM(2), .TICK_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n),
`ifdef CLINT_TIME_STOP_EN
    .time_stop(time_stop),
`endif
    .mtime_wen(mtime_wen), .mtimecmp_wen(mtimecmp_wen), .msip_wen(msip_wen),
    .reg_wdata(reg_wdata), .mtime(mtime_o[0]), .mtimecmp(mtimecmp_o[0]),
    .msip(msip_o[0]), .mtip(mtip_o[0])
  );

  clint_timer_ctrl #(.HART_NUM(2), .TICK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n),
`ifdef CLINT_TIME_STOP_EN
    .time_stop(time_stop),
`endif
    .mtime_wen(mtime_wen), .mtimecmp_wen(mtimecmp_wen), .msip_wen(msip_wen),
    .reg_wdata(reg_wdata), .mtime(mtime_o[1]), .mtimecmp(mtimecmp_o[1]),
    .msip(msip_o[1]), .mtip(mtip_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mtime = value last written + (running edges since that write) / TICK_DIV.
  logic [63:0] m_base  [2];
  logic [63:0] m_edges [2];
  logic [63:0] m_cmp   [2][2];
  logic [1:0]  m_msip  [2];
  logic [1:0]  m_mtip  [2];
  logic        model_valid = 1'b0;

  function automatic logic [63:0] div_of(input int k);
    return (k == 0) ? 64'd4 : 64'd1;
  endfunction

  function automatic logic [63:0] exp_mtime(input int k);
    return m_base[k] + (m_edges[k] / div_of(k));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_valid <= 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_base[k]  <= 64'd0;
        m_edges[k] <= 64'd0;
        m_cmp[k][0] <= 64'hFFFF_FFFF_FFFF_FFFF;
        m_cmp[k][1] <= 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[k]  <= 2'b00;
        m_mtip[k]  <= 2'b00;
      end else begin
        for (int h = 0; h < 2; h++) begin
          m_mtip[k][h] <= (exp_mtime(k) >= m_cmp[k][h]);
          if (mtimecmp_wen[h]) m_cmp[k][h] <= reg_wdata;
          if (msip_wen[h]) m_msip[k][h] <= (h == 1) ? reg_wdata[32] : reg_wdata[0];
        end
        if (mtime_wen) begin
          m_base[k]  <= reg_wdata;
          m_edges[k] <= 64'd0;
        end else if (!time_stop) begin
          m_edges[k] <= m_edges[k] + 64'd1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d mtime", k), mtime_o[k], exp_mtime(k));
        chk($sformatf("dut%0d mtimecmp0", k), mtimecmp_o[k][63:0], m_cmp[k][0]);
        chk($sformatf("dut%0d mtimecmp1", k), mtimecmp_o[k][127:64], m_cmp[k][1]);
        chk($sformatf("dut%0d msip", k), {62'd0, msip_o[k]}, {62'd0, m_msip[k]});
        chk($sformatf("dut%0d mtip", k), {62'd0, mtip_o[k]}, {62'd0, m_mtip[k]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mtime_wen    = 1'b0;
    mtimecmp_wen = 2'b00;
    msip_wen     = 2'b00;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d mtime", tag, k), mtime_o[k], 64'd0);
      chk($sformatf("%s dut%0d mtimecmp0", tag, k), mtimecmp_o[k][63:0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("%s dut%0d mtimecmp1", tag, k), mtimecmp_o[k][127:64], 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("%s dut%0d msip_mtip", tag, k), {60'd0, msip_o[k], mtip_o[k]}, 64'd0);
    end
  endtask

  initial begin
    int r;
    rst_n     = 1'b0;
    time_stop = 1'b0;
    reg_wdata = 64'd0;
    idle_inputs();
    step(2);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // First increment lands TICK_DIV edges after release.
    step(4);
    chk("div4 mtime@4", mtime_o[0], 64'd1);
    chk("div1 mtime@4", mtime_o[1], 64'd4);
    step(4);
    chk("div4 mtime@8", mtime_o[0], 64'd2);
    step(4);
    chk("div4 mtime@12", mtime_o[0], 64'd3);

    // Wrap from all ones.
    mtime_wen = 1'b1; reg_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1);
    mtime_wen = 1'b0;
    chk("div1 mtime load ones", mtime_o[1], 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    chk("div1 mtime wrap", mtime_o[1], 64'd0);

    // mtip[1] rises one cycle after mtime reaches mtimecmp[1].
    mtimecmp_wen = 2'b10; reg_wdata = 64'h10;
    step(1);
    mtimecmp_wen = 2'b00; mtime_wen = 1'b1; reg_wdata = 64'd0;
    step(1);
    mtime_wen = 1'b0;
    step(16);
    chk("div1 mtime at cmp", mtime_o[1], 64'h10);
    chk("div1 mtip before", {62'd0, mtip_o[1]}, 64'd0);
    step(1);
    chk("div1 mtip after", {62'd0, mtip_o[1]}, 64'd2);

    // msip lane selection by hart parity.
    msip_wen = 2'b11; reg_wdata = 64'h0000_0001_0000_0000;
    step(1);
    chk("msip upper lane", {62'd0, msip_o[0]}, 64'd2);
    reg_wdata = 64'h1;
    step(1);
    msip_wen = 2'b00;
    chk("msip lower lane", {62'd0, msip_o[0]}, 64'd1);

    // Write coincident with a tick on the TICK_DIV=4 instance.
    mtime_wen = 1'b1; reg_wdata = 64'h40;
    step(1);
    mtime_wen = 1'b0;
    step(3);
    chk("div4 before tick write", mtime_o[0], 64'h40);
    mtime_wen = 1'b1; reg_wdata = 64'h50;
    step(1);
    mtime_wen = 1'b0;
    chk("div4 write over tick", mtime_o[0], 64'h50);
    step(3);
    chk("div4 hold after write", mtime_o[0], 64'h50);
    step(1);
    chk("div4 next increment", mtime_o[0], 64'h51);

`ifdef CLINT_TIME_STOP_EN
    time_stop = 1'b1; mtime_wen = 1'b1; reg_wdata = 64'h100;
    step(1);
    mtime_wen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("stop div1 frozen", mtime_o[1], 64'h100);
    end
    time_stop = 1'b0;
    step(1);
    chk("stop div1 resume1", mtime_o[1], 64'h101);
    step(1);
    chk("stop div1 resume2", mtime_o[1], 64'h102);
`endif

    // Reset mid-run beats every coincident strobe.
    rst_n = 1'b0; mtime_wen = 1'b1; mtimecmp_wen = 2'b11; msip_wen = 2'b11;
    reg_wdata = 64'h0000_0001_0000_0001;
    step(1);
    chk_reset_state("midrun reset");
    rst_n = 1'b1;
    idle_inputs();

    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      mtime_wen    = ($urandom_range(0, 19) == 0);
      mtimecmp_wen = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      msip_wen     = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
`ifdef CLINT_TIME_STOP_EN
      time_stop    = ($urandom_range(0, 3) == 0);
`endif
      r = $urandom_range(0, 3);
      case (r)
        0:       reg_wdata = {$urandom, $urandom};
        1:       reg_wdata = 64'($urandom_range(0, 96));
        2:       reg_wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 8));
        default: reg_wdata = exp_mtime(1) + 64'($urandom_range(0, 6));
      endcase
      step(1);
    end
    idle_inputs();
    rst_n = 1'b1;
    time_stop = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_timer_ctrl.md
CLINT_TIMER_CTRL -- requirements
Module: clint_timer_ctrl

Interface
REQ-001 SHALL have parameter HART_NUM, default 1, meaning the number of harts served (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 100, meaning clk cycles per mtime increment (1..65535).
REQ-003 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-005 SHALL have port mtime_wen, input, 1, mtime write strobe.
REQ-006 SHALL have port mtimecmp_wen, input, HART_NUM, per-hart mtimecmp write strobes.
REQ-007 SHALL have port msip_wen, input, HART_NUM, per-hart msip write strobes.
REQ-008 SHALL have port reg_wdata, input, 64, merged write data.
REQ-009 SHALL have port mtime, output, 64, current timer value.
REQ-010 SHALL have port mtimecmp, output, 64*HART_NUM, compare values; hart i occupies bits [64i+63:64i].
REQ-011 SHALL have port msip, output, HART_NUM, software interrupt pending per hart.
REQ-012 SHALL have port mtip, output, HART_NUM, timer interrupt pending per hart.

Function
REQ-013 SHALL hold a prescaler counter of ceil(log2(TICK_DIV+1)) bits that counts 0..TICK_DIV-1 and wraps to 0.
REQ-014 SHALL assert an internal tick in the cycle the prescaler equals TICK_DIV-1; TICK_DIV=1 gives a tick every cycle.
REQ-015 SHALL increment mtime by 1 on the edge following a tick, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF -> 0, no flag).
REQ-016 SHALL, on mtime_wen, load mtime with reg_wdata at the next edge and clear the prescaler to 0; write has priority over a coincident tick.
REQ-017 SHALL, on mtimecmp_wen[i], load mtimecmp for hart i with reg_wdata at the next edge.
REQ-018 SHALL, on msip_wen[i], load msip[i] from reg_wdata bit 0 when i is even, bit 32 when i is odd; other bits are ignored.
REQ-019 SHALL allow any combination of strobes in one cycle; each target register updates independently.
REQ-020 SHALL register mtip[i] = (mtime >= mtimecmp[i]) as unsigned 64-bit compare of the current register values, giving one cycle latency after either register changes.
REQ-021 SHALL keep mtip level-sensitive: it deasserts one cycle after mtimecmp is raised above mtime or mtime is written below mtimecmp.
REQ-022 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while rst_n is low at a clk edge, set mtime=0, all mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, prescaler=0.
REQ-024 SHALL give reset priority over every write strobe and tick in the same cycle.
REQ-025 SHALL resume counting from prescaler 0 on the first edge with rst_n high, so the first increment lands TICK_DIV edges after reset release.

Configuration
REQ-026 SHALL, when macro CLINT_TIME_STOP_EN is defined, add input port time_stop (1 bit) that freezes both prescaler and mtime while high; mtime_wen still loads mtime and clears the prescaler.
REQ-027 SHALL, when CLINT_TIME_STOP_EN is undefined, have no time_stop port and count unconditionally.

Verification
REQ-028 SHALL cover: TICK_DIV=4, reset released -> mtime reads 1 after 4 edges, 2 after 8, 3 after 12.
REQ-029 SHALL cover: mtime_wen with reg_wdata=0xFFFF_FFFF_FFFF_FFFF, TICK_DIV=1 -> mtime=0xFFFF_FFFF_FFFF_FFFF next edge, 0 on the following edge.
REQ-030 SHALL cover: HART_NUM=2, mtimecmp_wen[1] with 0x10, mtime counting from 0 at TICK_DIV=1 -> mtip[1] rises one cycle after mtime reaches 0x10, while mtip[0] stays 0.
REQ-031 SHALL cover: msip_wen=2'b11 with reg_wdata=0x0000_0001_0000_0000 -> msip=2'b10; then reg_wdata=0x1 -> msip=2'b01.
REQ-032 SHALL cover: mtime_wen with 0x50 coincident with a tick -> mtime=0x50 (not 0x51) and the next increment comes TICK_DIV edges later.
REQ-033 SHALL cover: with CLINT_TIME_STOP_EN, time_stop high for 20 cycles at TICK_DIV=1 -> mtime constant, then resumes +1 per cycle; reset asserted mid-run -> all REQ-023 values on the next edge.
